// File: rtl/store_unit.sv
// store_unit: memory-stage store path. Checks store alignment, formats
// lane-replicated write data and byte enables, buffers stores in a small
// FIFO and drains them to data memory over a req/gnt handshake. Also
// flags loads that overlap any pending store word.

// Per-entry word-address compare used for load hazard detection.
module store_unit_cmp (
  input  logic        vld_i,
  input  logic [29:0] waddr_i,
  input  logic [29:0] ld_waddr_i,
  output logic        hit_o
);
  assign hit_o = vld_i && (waddr_i == ld_waddr_i);
endmodule

module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m_store_valid_i,
  input  logic [2:0]  m_store_funct3_i,
  input  logic [31:0] m_store_addr_i,
  input  logic [31:0] m_store_data_i,
  output logic        store_ready_o,
  output logic        store_err_o,
  output logic [31:0] store_err_addr_o,
  output logic        dm_req_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_din_o,
  output logic [3:0]  dm_be_o,
  input  logic        dm_gnt_i,
  input  logic        ld_check_i,
  input  logic [31:0] ld_addr_i,
  output logic        ld_hazard_o,
  output logic        sb_empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] din;
    logic [3:0]  be;
  } sb_entry_t;

  sb_entry_t [DEPTH-1:0] ent_q;
  logic [DEPTH-1:0]      vld_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  err_q;
  logic [31:0]           err_addr_q;

  sb_entry_t new_ent;
  sb_entry_t head;
  logic      legal, accept, push, bad, pop;
  logic [DEPTH-1:0] hit;
  logic      unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr_i[1:0];

  // Width/alignment check and lane formatting of the incoming store.
  always_comb begin
    new_ent       = '0;
    legal         = 1'b0;
    new_ent.waddr = m_store_addr_i[31:2];
    case (m_store_funct3_i)
      3'b000: begin
        legal       = 1'b1;
        new_ent.din = {4{m_store_data_i[7:0]}};
        new_ent.be  = 4'b0001 << m_store_addr_i[1:0];
      end
      3'b001: begin
        legal       = ~m_store_addr_i[0];
        new_ent.din = {2{m_store_data_i[15:0]}};
        new_ent.be  = m_store_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        legal       = (m_store_addr_i[1:0] == 2'b00);
        new_ent.din = m_store_data_i;
        new_ent.be  = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

  assign store_ready_o = (count_q != CNT_FULL);
  assign sb_empty_o    = (count_q == '0);
  assign accept        = m_store_valid_i && store_ready_o;
  assign push          = accept && legal;
  assign bad           = accept && !legal;
  assign dm_req_o      = !sb_empty_o;
  assign pop           = dm_req_o && dm_gnt_i;

  // Memory port is fed straight from the head register; zeroed when idle.
  assign head      = ent_q[rd_ptr_q];
  assign dm_addr_o = dm_req_o ? {head.waddr, 2'b00} : '0;
  assign dm_din_o  = dm_req_o ? head.din : '0;
  assign dm_be_o   = dm_req_o ? head.be : '0;

  // Hazard compares only registered entries, so a same-cycle enqueue is
  // invisible while the entry being granted still counts.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    store_unit_cmp u_cmp (
      .vld_i      (vld_q[i]),
      .waddr_i    (ent_q[i].waddr),
      .ld_waddr_i (ld_addr_i[31:2]),
      .hit_o      (hit[i])
    );
  end
  assign ld_hazard_o = ld_check_i && |hit;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ent_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        ent_q[wr_ptr_q] <= new_ent;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // One-cycle error pulse; the offending address is held until the next error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= bad;
      if (bad) err_addr_q <= m_store_addr_i;
    end
  end

  assign store_err_o      = err_q;
  assign store_err_addr_o = err_addr_q;
endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Memory-stage store path for the data memory.
- Accepts store requests (funct3, byte address, rs2 data) and checks alignment.
- Generates word-aligned address, lane-replicated write data and byte enables.
- Queues stores in a small FIFO and drains them to data memory over a req/gnt handshake; flags when a pending store hazards an issuing load.
- Counterpart of the load-extraction path in the writeback mux.

Parameters:
- DEPTH, 2, number of store-buffer entries; power of 2, >= 2.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  asynchronous active-low reset
- m_store_valid_i  input  1  store request this cycle
- m_store_funct3_i  input  3  store width: 000 SB, 001 SH, 010 SW
- m_store_addr_i  input  32  byte address (ALU result)
- m_store_data_i  input  32  rs2 value, data in low bits
- store_ready_o  output  1  buffer can accept (not full)
- store_err_o  output  1  one-cycle pulse: misaligned or illegal-width store rejected
- store_err_addr_o  output  32  address of last rejected store
- dm_req_o  output  1  write request to data memory
- dm_addr_o  output  32  word-aligned write address
- dm_din_o  output  32  write data
- dm_be_o  output  4  byte enables, bit n = byte lane n
- dm_gnt_i  input  1  memory accepts head entry this cycle
- ld_check_i  input  1  a load is issuing this cycle
- ld_addr_i  input  32  load byte address
- ld_hazard_o  output  1  load overlaps a pending store word
- sb_empty_o  output  1  no pending stores (used for fence)

Behaviour:
- Reset (async, rst_n_i low):
  - all entries invalidated; read/write pointers and count = 0.
  - dm_req_o = 0; dm_addr_o, dm_din_o, dm_be_o = 0.
  - store_err_o = 0; store_err_addr_o = 0; store_ready_o = 1; sb_empty_o = 1.
  - Reset mid-drain discards all pending stores; no request is reissued.
- Accept: on a clock edge with m_store_valid_i && store_ready_o, one of:
  - Legal and aligned: enqueue {word addr = addr[31:2], din, be}.
  - Misaligned (SH with addr[0]=1; SW with addr[1:0]!=0) or funct3 not in {000,001,010}: not enqueued. Next cycle store_err_o=1 for exactly one cycle and store_err_addr_o = m_store_addr_i (held until the next error).
- m_store_valid_i while full is ignored (no enqueue, no error). The upstream pipeline must stall on !store_ready_o.
- Lane formatting, computed at enqueue:
  - SB: din = {4{data[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: din = {2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: din = data, be = 4'b1111.
- Drain:
  - dm_req_o = 1 whenever count > 0. dm_addr_o = {head word addr, 2'b00}; dm_din_o and dm_be_o come from the head entry.
  - Outputs are driven directly from buffer registers, so latency from enqueue into an empty buffer to dm_req_o is 1 cycle.
  - While dm_req_o=1 and dm_gnt_i=0, all dm_* outputs hold stable.
  - On dm_gnt_i=1 with dm_req_o=1, the head is popped and the next entry is presented in the following cycle. Back-to-back grants drain one entry per cycle.
  - dm_gnt_i while dm_req_o=0 is ignored.
  - When the buffer is idle, dm_addr_o, dm_din_o and dm_be_o are 0.
- Simultaneous enqueue and pop:
  - Allowed when not full; count is unchanged.
  - When full, store_ready_o=0 in that cycle even if a grant arrives; no bypass.
  - Pointers wrap modulo DEPTH.
- store_ready_o = (count != DEPTH); sb_empty_o = (count == 0). Both are derived from registered count.
- ld_hazard_o, combinational: ld_check_i && any valid entry with word addr == ld_addr_i[31:2].
  - Includes the head entry being granted this cycle.
  - Excludes a store being enqueued this cycle.
  - No store-to-load forwarding; the load pipeline stalls until ld_hazard_o=0.

Test Plan:
1. Reset, then SW addr 0x100 data 0xDEADBEEF, gnt tied 1 -> next cycle dm_req_o=1, dm_addr_o=0x100, dm_din_o=0xDEADBEEF, dm_be_o=4'b1111. Cycle after: dm_req_o=0, sb_empty_o=1.
2. SB addr 0x203 data 0x000000A5, then SH addr 0x206 data 0x00001234, gnt held 0 -> store_ready_o=0 after both enqueue (DEPTH=2). Head holds dm_din_o=0xA5A5A5A5, be=4'b1000, addr 0x200 stable. Raise gnt two cycles -> second beat dm_addr_o=0x204, dm_din_o=0x12341234, be=4'b1100.
3. SW addr 0x102 -> no enqueue, store_err_o=1 for one cycle, store_err_addr_o=0x102. SH addr 0x301 -> same with 0x301. funct3=011 -> same error; sb_empty_o stays 1.
4. Buffer holds SW 0x400 with gnt=0; ld_check_i=1 with ld_addr_i=0x402 -> ld_hazard_o=1. ld_addr_i=0x404 -> 0. After grant pops the entry -> 0x402 gives 0.
5. One entry pending, gnt=1 and new store valid in the same cycle -> count stays 1, new entry presented next cycle. Streaming 8 stores with gnt=1 every cycle -> 8 consecutive dm_req_o beats, in order, no drops.
6. Two entries pending, assert rst_n_i low mid-cycle -> dm_req_o drops to 0 immediately. After release: sb_empty_o=1, store_ready_o=1, no stale request appears.
